age_issue_queue: RTL and testbench

- Parametrised successor to the combinational 16-entry oldest-first arbiter.
- Holds dispatched instructions in DEPTH entries and tracks source-operand readiness via wakeup tag broadcasts.
- Each cycle, selects the oldest entry whose opcode matches and whose operands are both ready, then issues it through a registered valid/ready output stage.
- Sits between rename/dispatch and one functional unit. One instance per FU class.

---
 rtl/age_issue_queue.sv | 138 +++++++++++++
 tb/tb_age_issue_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/age_issue_queue.sv
// Oldest-first issue queue with wakeup; an entry eligible in cycle t shows on iss_valid at t+1.
// A stalled output stage holds its contents and blocks further loads; dispatch stalls only when full.
module age_issue_queue #(
  parameter int                      DEPTH        = 16,
  parameter int                      OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] OP           = 7'b0110011,
  parameter bit                      MATCH_ALL    = 1'b0,
  parameter int                      TAG_W        = 6,
  parameter int                      PAYLOAD_W    = 64,
  parameter int                      NWAKE        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OPCODE_WIDTH-1:0]    disp_op,
  input  logic [TAG_W-1:0]           disp_src1_tag,
  input  logic [TAG_W-1:0]           disp_src2_tag,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [NWAKE-1:0]           wake_valid,
  input  logic [NWAKE*TAG_W-1:0]     wake_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OPCODE_WIDTH-1:0]    iss_op,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic                    vld;
    logic [OPCODE_WIDTH-1:0] op;
    logic [TAG_W-1:0]        s1_tag;
    logic                    s1_rdy;
    logic [TAG_W-1:0]        s2_tag;
    logic                    s2_rdy;
    logic [PAYLOAD_W-1:0]    payload;
    logic [AW-1:0]           age;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] elig;
  logic             free_found;
  logic [AW-1:0]    free_idx;
  logic             any_elig;
  logic [AW-1:0]    sel_idx;
  logic [AW-1:0]    sel_age;
  logic             accept;
  logic             load;

  function automatic logic woken(input logic [TAG_W-1:0]       tag,
                                 input logic [NWAKE-1:0]       wv,
                                 input logic [NWAKE*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWAKE; k++) begin
      if (wv[k] && (wt[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = ent[i].vld && (MATCH_ALL || (ent[i].op == OP)) && ent[i].s1_rdy && ent[i].s2_rdy;
    end
  end

  // Free-slot search and oldest-eligible search both use state from the start of the cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    any_elig   = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent[i].vld && !free_found) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
      if (elig[i] && (!any_elig || (ent[i].age < sel_age))) begin
        any_elig = 1'b1;
        sel_idx  = AW'(i);
        sel_age  = ent[i].age;
      end
    end
  end

  assign disp_ready = !rst && (count != CW'(DEPTH));
  assign accept     = disp_valid && disp_ready;
  assign load       = (!iss_valid || iss_ready) && any_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_op      <= '0;
      iss_payload <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
      count     <= '0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].vld) begin
          if (woken(ent[i].s1_tag, wake_valid, wake_tag)) ent[i].s1_rdy <= 1'b1;
          if (woken(ent[i].s2_tag, wake_valid, wake_tag)) ent[i].s2_rdy <= 1'b1;
          if (load && (sel_idx == AW'(i))) ent[i].vld <= 1'b0;
          else if (load && (ent[i].age > sel_age)) ent[i].age <= ent[i].age - 1'b1;
        end
      end
      // The target slot was free at cycle start, so it never collides with the updates above.
      if (accept) begin
        ent[free_idx] <= '{vld:     1'b1,
                           op:      disp_op,
                           s1_tag:  disp_src1_tag,
                           s1_rdy:  disp_src1_rdy || woken(disp_src1_tag, wake_valid, wake_tag),
                           s2_tag:  disp_src2_tag,
                           s2_rdy:  disp_src2_rdy || woken(disp_src2_tag, wake_valid, wake_tag),
                           payload: disp_payload,
                           age:     AW'(count - CW'(load))};
      end
      if (load) begin
        iss_valid   <= 1'b1;
        iss_op      <= ent[sel_idx].op;
        iss_payload <= ent[sel_idx].payload;
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
      count <= count + CW'(accept) - CW'(load);
    end
  end
endmodule

// File: tb/tb_age_issue_queue.sv
// Scoreboard bench: expected payloads queued at dispatch, popped on each issue handshake.
module tb_age_issue_queue;
  localparam int         DEPTH = 16;
  localparam int         TW    = 6;
  localparam int         PW    = 64;
  localparam int         NW    = 2;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          disp_valid, disp_ready;
  logic [6:0]    disp_op;
  logic [TW-1:0] disp_src1_tag, disp_src2_tag;
  logic          disp_src1_rdy, disp_src2_rdy;
  logic [PW-1:0] disp_payload;
  logic [NW-1:0] wake_valid;
  logic [NW*TW-1:0] wake_tag;
  logic          iss_valid, iss_ready;
  logic [6:0]    iss_op;
  logic [PW-1:0] iss_payload;
  logic [4:0]    count;

  logic          m_flush, m_disp_valid, m_disp_ready, m_iss_valid, m_iss_ready;
  logic [6:0]    m_iss_op;
  logic [PW-1:0] m_iss_payload;
  logic [4:0]    m_count;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PW-1:0] sb [$];

  always #5 clk = ~clk;

  age_issue_queue #(.DEPTH(DEPTH), .MATCH_ALL(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload), .wake_valid(wake_valid), .wake_tag(wake_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_payload(iss_payload), .count(count));

  age_issue_queue #(.DEPTH(DEPTH), .MATCH_ALL(1'b1)) dut_ma (
    .clk(clk), .rst(rst), .flush(m_flush),
    .disp_valid(m_disp_valid), .disp_ready(m_disp_ready), .disp_op(OP_LD),
    .disp_src1_tag(6'd0), .disp_src2_tag(6'd0),
    .disp_src1_rdy(1'b1), .disp_src2_rdy(1'b1),
    .disp_payload(64'hBEEF), .wake_valid(2'b00), .wake_tag(12'd0),
    .iss_valid(m_iss_valid), .iss_ready(m_iss_ready), .iss_op(m_iss_op),
    .iss_payload(m_iss_payload), .count(m_count));

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [6:0] op, input logic [TW-1:0] t1, input logic r1,
                      input logic [TW-1:0] t2, input logic r2, input logic [PW-1:0] pl,
                      input bit expect_issue);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_src1_tag = t1;
    disp_src1_rdy = r1;
    disp_src2_tag = t2;
    disp_src2_rdy = r2;
    disp_payload  = pl;
    if (expect_issue) sb.push_back(pl);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wake_valid = '0;
  endtask

  task automatic drain();
    iss_ready = 1'b1;
    for (int i = 0; i < 100 && (sb.size() != 0 || iss_valid); i++) step();
    check("drain_done", 64'(sb.size() == 0 && !iss_valid), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      if (sb.size() == 0) check("sb_empty_on_issue", 64'(sb.size()), 64'd1);
      else begin
        check("iss_payload", iss_payload, sb.pop_front());
        check("iss_op", 64'(iss_op), 64'(OP_R));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0; m_flush = 1'b0;
    m_disp_valid = 1'b0; m_iss_ready = 1'b1;
    disp_op = OP_R; disp_src1_tag = '0; disp_src2_tag = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_payload = '0; wake_tag = '0;
    idle();
    step(); step();
    check("rst_disp_ready", 64'(disp_ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_op", 64'(iss_op), 64'd0);
    check("rst_iss_payload", iss_payload, 64'd0);
    rst = 1'b0;
    step();
    check("disp_ready_after_rst", 64'(disp_ready), 64'd1);

    // In-order issue of three ready entries.
    iss_ready = 1'b1;
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'hA, 1'b1); step();
    check("a_count", 64'(count), 64'd1);
    check("a_not_yet", 64'(iss_valid), 64'd0);
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'hB, 1'b1); step();
    check("a_latency_vld", 64'(iss_valid), 64'd1);
    check("a_latency_pl", iss_payload, 64'hA);
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'hC, 1'b1); step();
    idle(); step(); step();
    check("abc_empty_vld", 64'(iss_valid), 64'd0);
    check("abc_empty_count", 64'(count), 64'd0);

    // Age order beats readiness order; the output stage is held by W meanwhile.
    iss_ready = 1'b0;
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'h57, 1'b1); step();
    disp(OP_R, 6'd5, 1'b0, 6'd0, 1'b1, 64'h58, 1'b1); step();
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'h59, 1'b1); step();
    idle(); wake_valid = 2'b01; wake_tag = {6'd0, 6'd5}; step();
    idle();
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", 64'(iss_valid), 64'd1);
      check("hold_pl", iss_payload, 64'h57);
      check("hold_count", 64'(count), 64'd2);
      step();
    end
    drain();

    // Full queue boundary.
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_R, 6'd9, 1'b0, 6'd0, 1'b1, 64'h100 + 64'(i), 1'b1); step();
    end
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(disp_ready), 64'd0);
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'hDEAD, 1'b0); step();
    check("full_reject", 64'(count), 64'd16);
    idle(); wake_valid = 2'b10; wake_tag = {6'd9, 6'd0}; step();
    idle(); step();
    check("full_load_vld", 64'(iss_valid), 64'd1);
    check("full_load_pl", iss_payload, 64'h100);
    check("full_load_count", 64'(count), 64'd15);
    check("full_ready_again", 64'(disp_ready), 64'd1);
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'h200, 1'b1); step();
    idle();
    check("refill_count", 64'(count), 64'd16);
    drain();

    // Opcode filter, with and without MATCH_ALL.
    iss_ready = 1'b1;
    disp(OP_LD, 6'd0, 1'b1, 6'd0, 1'b1, 64'h77, 1'b0);
    m_disp_valid = 1'b1; step();
    idle(); m_disp_valid = 1'b0; step();
    check("ma_vld", 64'(m_iss_valid), 64'd1);
    check("ma_op", 64'(m_iss_op), 64'(OP_LD));
    check("ma_pl", m_iss_payload, 64'hBEEF);
    repeat (4) step();
    check("ld_stuck_count", 64'(count), 64'd1);
    check("ld_no_issue", 64'(iss_valid), 64'd0);
    check("ma_drained", 64'(m_count), 64'd0);

    // Flush drops the held output, the queue and a same-cycle dispatch.
    iss_ready = 1'b0;
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'h300, 1'b1); step();
    idle(); step();
    check("pre_flush_vld", 64'(iss_valid), 64'd1);
    check("pre_flush_pl", iss_payload, 64'h300);
    check("pre_flush_count", 64'(count), 64'd1);
    flush = 1'b1;
    disp(OP_R, 6'd0, 1'b1, 6'd0, 1'b1, 64'h301, 1'b0);
    sb.delete(); step();
    flush = 1'b0; idle();
    check("flush_vld", 64'(iss_valid), 64'd0);
    check("flush_count", 64'(count), 64'd0);
    iss_ready = 1'b1;
    repeat (3) step();
    check("flush_disp_dropped", 64'(count), 64'd0);
    check("flush_no_issue", 64'(iss_valid), 64'd0);

    // Wakeup on the dispatch cycle is captured.
    disp(OP_R, 6'd0, 1'b1, 6'd12, 1'b0, 64'h400, 1'b1);
    wake_valid = 2'b10; wake_tag = {6'd12, 6'd0}; step();
    idle();
    check("dw_plus1", 64'(iss_valid), 64'd0);
    step();
    check("dw_plus2_vld", 64'(iss_valid), 64'd1);
    check("dw_plus2_pl", iss_payload, 64'h400);
    drain();
    check("final_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
